// File: rtl/mul_int_sched_if.sv
// Bundle of request, datapath and response signals for mul_int_sched.
// Every valid/ready pair follows the same contract: a transfer happens on a
// rising clock edge where valid and ready are both high; once the producer
// raises valid it holds valid and its payload stable until it sees ready;
// valid never depends on ready, while ready may depend on valid.
interface mul_int_sched_if #(
  parameter int WIDTH = 32
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req0_sgn;

  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               req1_sgn;

  logic               mul_issue;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_sgn;
  logic [2*WIDTH-1:0] mul_result;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_data;

  // Environment side: requesters, multiplier datapath and response consumer.
  modport master (
    output req0_valid, req0_a, req0_b, req0_sgn,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sgn,
    input  req1_ready,
    input  mul_issue, mul_a, mul_b, mul_sgn,
    output mul_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sgn,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sgn,
    output req1_ready,
    output mul_issue, mul_a, mul_b, mul_sgn,
    input  mul_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );
endinterface

// File: rtl/mul_int_sched.sv
// Two-requester scheduler for a shared fixed-latency pipelined multiplier.
// Round-robin grant, a LAT-deep {valid,id} tracking pipe that mirrors the
// datapath, and a DEPTH-entry result FIFO. Issue is throttled by credits
// (FIFO slots minus buffered minus in-flight results) so a returning result
// always finds room. The interface instance must use the same WIDTH.
module mul_int_sched #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input logic            clock,
  input logic            reset,
  mul_int_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 1) + 1;

  logic [LAT-1:0]   pipe_v;
  logic [LAT-1:0]   pipe_id;
  logic [2*WIDTH:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             prio;

  logic [CW-1:0]    inflight;
  logic [CW-1:0]    used;
  logic             push;
  logic             pop;
  logic             can_issue;
  logic             any_valid;
  logic             grant_id;
  logic             issue;

  // Number of operations currently travelling through the datapath.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(pipe_v[i]);
    end
  end

  assign used      = count + inflight;
  assign push      = pipe_v[LAT-1];
  assign pop       = bus.rsp_valid && bus.rsp_ready;

  // A pop this cycle frees a slot early enough to cover a new issue.
  assign can_issue = !reset &&
                     ((used < CW'(DEPTH)) || ((used == CW'(DEPTH)) && pop));

  // Priority pointer only matters when both requesters are valid.
  assign any_valid = bus.req0_valid || bus.req1_valid;
  assign grant_id  = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
  assign issue     = can_issue && any_valid;

  assign bus.req0_ready = issue && !grant_id;
  assign bus.req1_ready = issue && grant_id;
  assign bus.mul_issue  = issue;
  assign bus.mul_a      = issue ? (grant_id ? bus.req1_a   : bus.req0_a)   : '0;
  assign bus.mul_b      = issue ? (grant_id ? bus.req1_b   : bus.req0_b)   : '0;
  assign bus.mul_sgn    = issue ? (grant_id ? bus.req1_sgn : bus.req0_sgn) : 1'b0;

  // Head of the FIFO; forced to zero while empty so stale entries never leak.
  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_id    = bus.rsp_valid ? mem[rd_ptr][2*WIDTH]     : 1'b0;
  assign bus.rsp_data  = bus.rsp_valid ? mem[rd_ptr][2*WIDTH-1:0] : '0;

  // Tracking pipe shifts every cycle, aligned with the datapath latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= issue;
      pipe_id[0] <= issue && grant_id;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  // Round-robin pointer hands priority to the other requester after a grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (issue) begin
      prio <= !grant_id;
    end
  end

  // FIFO occupancy and pointers; push and pop together leave count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only observable through a non-zero count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {pipe_id[LAT-1], bus.mul_result};
    end
  end
endmodule

// File: tb/tb_mul_int_sched.sv
// Directed and random bench for mul_int_sched with a behavioural multiplier
// datapath and a scoreboard of expected {id, product} in issue order.
module tb_mul_int_sched;
  localparam int W     = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clock;
  logic reset;

  mul_int_sched_if #(.WIDTH(W)) bus ();

  mul_int_sched #(.WIDTH(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_issue = 0;
  int n_rsp   = 0;

  logic [2*W:0]   exp_q[$];
  logic [2*W:0]   rsp_log[$];
  logic [2*W-1:0] dp_pipe [LAT];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;
    ax = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ax * bx;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {{(2*W){1'b0}}, got}, {{(2*W){1'b0}}, exp});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    tick();
    reset = 1'b0;
    rsp_log.delete();
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < 60) begin
      @(negedge clock);
      k++;
    end
    chk("log_count", (2*W+1)'(rsp_log.size()), (2*W+1)'(n));
  endtask

  task automatic chk_log(input string tag, input int idx, input logic id,
                         input logic [2*W-1:0] data);
    logic [2*W:0] got;
    got = (idx < rsp_log.size()) ? rsp_log[idx] : '1;
    chk(tag, got, {id, data});
  endtask

  // ---------------- behavioural multiplier datapath ----------------
  always @(posedge clock) begin
    dp_pipe[0] <= bus.mul_issue ? prod(bus.mul_a, bus.mul_b, bus.mul_sgn) : '0;
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign bus.mul_result = dp_pipe[LAT-1];

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [2*W:0] e;
    if (reset) begin
      exp_q.delete();
      n_issue = 0;
      n_rsp   = 0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_log.push_back({bus.rsp_id, bus.rsp_data});
        n_rsp++;
        n_tests++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        assert ({bus.rsp_id, bus.rsp_data} === e) else begin
          n_fail++;
          $error("FAIL sb_rsp: observed %0h expected %0h", {bus.rsp_id, bus.rsp_data}, e);
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        exp_q.push_back({1'b0, prod(bus.req0_a, bus.req0_b, bus.req0_sgn)});
        n_issue++;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        exp_q.push_back({1'b1, prod(bus.req1_a, bus.req1_b, bus.req1_sgn)});
        n_issue++;
      end
      n_tests++;
      assert (!(dut.pipe_v[LAT-1] && dut.count == DEPTH)) else begin
        n_fail++;
        $error("FAIL push_full: observed push with count %0d expected no push", dut.count);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int hs;
    logic hs0;
    logic hs1;

    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd6; bus.req0_sgn = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0;    bus.req1_b = '0;    bus.req1_sgn = 1'b0;
    bus.rsp_ready  = 1'b1;

    // Test 1: outputs held at zero in reset, then a lone 7 x 6.
    @(negedge clock);
    chk1("rst_req0_ready", bus.req0_ready, 1'b0);
    chk1("rst_req1_ready", bus.req1_ready, 1'b0);
    chk1("rst_mul_issue",  bus.mul_issue,  1'b0);
    chk1("rst_rsp_valid",  bus.rsp_valid,  1'b0);
    chk("rst_mul_a",    (2*W+1)'(bus.mul_a), '0);
    chk("rst_rsp_data", {bus.rsp_id, bus.rsp_data}, '0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk1("t1_req0_ready", bus.req0_ready, 1'b1);
    chk1("t1_req1_ready", bus.req1_ready, 1'b0);
    chk1("t1_mul_issue",  bus.mul_issue,  1'b1);
    chk("t1_mul_a", (2*W+1)'(bus.mul_a), 65'd7);
    chk("t1_mul_b", (2*W+1)'(bus.mul_b), 65'd6);
    chk1("t1_mul_sgn", bus.mul_sgn, 1'b0);
    tick();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    @(negedge clock);
    chk1("t1_idle_issue", bus.mul_issue, 1'b0);
    chk("t1_idle_mul_a", (2*W+1)'(bus.mul_a), '0);
    chk1("t1_rsp_early1", bus.rsp_valid, 1'b0);
    tick();
    @(negedge clock);
    chk1("t1_rsp_early2", bus.rsp_valid, 1'b0);
    tick();
    @(negedge clock);
    chk1("t1_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t1_rsp", {bus.rsp_id, bus.rsp_data}, {1'b0, 64'd42});

    // Test 2: both requesters valid, grants alternate starting at 0.
    do_reset();
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd3;         bus.req0_b = 32'd5; bus.req0_sgn = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFE; bus.req1_b = 32'd4; bus.req1_sgn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk1("t2_grant0", bus.req0_ready, (k % 2) == 0);
      chk1("t2_grant1", bus.req1_ready, (k % 2) == 1);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_log(4);
    chk_log("t2_rsp0", 0, 1'b0, 64'd15);
    chk_log("t2_rsp1", 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    chk_log("t2_rsp2", 2, 1'b0, 64'd15);
    chk_log("t2_rsp3", 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);

    // Test 3/4: fill the FIFO with rsp_ready low, then use the pop-credit path.
    do_reset();
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd10; bus.req0_b = 32'd3; bus.req0_sgn = 1'b0;
    hs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      hs0 = bus.req0_valid && bus.req0_ready;
      if (hs0) hs++;
      if (c == 7) begin
        chk1("t3_stalled_ready", bus.req0_ready, 1'b0);
        chk1("t3_full_valid", bus.rsp_valid, 1'b1);
        chk("t3_head", {bus.rsp_id, bus.rsp_data}, {1'b0, 64'd30});
      end
      tick();
      if (hs0) bus.req0_a = 32'd10 + 32'(hs);
    end
    chk("t3_handshakes", (2*W+1)'(hs), (2*W+1)'(DEPTH));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFD; bus.req1_b = 32'd5; bus.req1_sgn = 1'b1;
    bus.rsp_ready  = 1'b1;
    @(negedge clock);
    chk1("t4_pop_credit_ready", bus.req1_ready, 1'b1);
    tick();
    bus.rsp_ready  = 1'b0;
    bus.req1_a = 32'd2; bus.req1_b = 32'd2; bus.req1_sgn = 1'b0;
    @(negedge clock);
    chk1("t4_no_credit", bus.req1_ready, 1'b0);
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    chk1("t4_pop_credit_again", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    wait_log(6);
    chk_log("t3_rsp0", 0, 1'b0, 64'd30);
    chk_log("t3_rsp1", 1, 1'b0, 64'd33);
    chk_log("t3_rsp2", 2, 1'b0, 64'd36);
    chk_log("t3_rsp3", 3, 1'b0, 64'd39);
    chk_log("t4_rsp4", 4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    chk_log("t4_rsp5", 5, 1'b1, 64'd4);

    // Test 5: reset with two in flight and one buffered.
    do_reset();
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd2; bus.req0_b = 32'd2; bus.req0_sgn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk1("t5_fill_ready", bus.req0_ready, 1'b1);
      tick();
      bus.req0_a = 32'd3 + 32'(c);
    end
    reset = 1'b1;
    #1;
    chk1("t5_rst_req0_ready", bus.req0_ready, 1'b0);
    chk1("t5_rst_mul_issue",  bus.mul_issue,  1'b0);
    chk1("t5_rst_rsp_valid",  bus.rsp_valid,  1'b0);
    chk("t5_rst_rsp", {bus.rsp_id, bus.rsp_data}, '0);
    chk("t5_rst_mul_ab", {1'b0, bus.mul_a, bus.mul_b}, '0);
    tick();
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk1("t5_no_stale", bus.rsp_valid, 1'b0);
      tick();
    end
    bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd9; bus.req1_sgn = 1'b0;
    @(negedge clock);
    chk1("t5_next_ready", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    wait_log(1);
    chk_log("t5_rsp", 0, 1'b1, 64'd81);

    // Test 6: random traffic on both ports against the scoreboard.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clock);
      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;
      tick();
      if (!bus.req0_valid || hs0) begin
        bus.req0_valid = ($urandom_range(0, 3) != 0);
        bus.req0_a = pick(); bus.req0_b = pick(); bus.req0_sgn = 1'($urandom_range(0, 1));
      end
      if (!bus.req1_valid || hs1) begin
        bus.req1_valid = ($urandom_range(0, 3) != 0);
        bus.req1_a = pick(); bus.req1_b = pick(); bus.req1_sgn = 1'($urandom_range(0, 1));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    hs0 = bus.req0_valid && bus.req0_ready;
    hs1 = bus.req1_valid && bus.req1_ready;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clock);
    chk("t6_drained", (2*W+1)'(exp_q.size()), '0);
    chk("t6_issue_vs_rsp", (2*W+1)'(n_rsp), (2*W+1)'(n_issue));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
